// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: shared widths, instruction field positions, opcode and FSM state types
package regfile_seq_pkg;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int INSTR_W = 16;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RA_LSB  = 4;
    localparam int RB_LSB  = 0;
    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
        OP_SHL = 4'h8, OP_SHR = 4'h9, OP_MOV = 4'hA
    } opcode_t;
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
endpackage

// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if: instruction handshake and retirement status between control logic and sequencer
interface regfile_sequencer_if;
    import regfile_seq_pkg::*;
    logic [INSTR_W-1:0] instr;
    logic instr_valid;
    logic instr_ready;
    logic done;
    logic err;
    logic flag_c;
    logic flag_z;
    logic busy;
    modport master (output instr, instr_valid, input instr_ready, done, err, flag_c, flag_z, busy);
    modport slave (input instr, instr_valid, output instr_ready, done, err, flag_c, flag_z, busy);
endinterface

// File: rtl/regfile_alu.sv
// regfile_alu: combinational ALU computing result, flags and write/flag-update/illegal qualifiers
module regfile_alu
    import regfile_seq_pkg::*;
(
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm8,
    output logic [DATA_W-1:0] result,
    output logic              c,
    output logic              z,
    output logic              writes_rd,
    output logic              updates_flags,
    output logic              illegal
);
    logic [DATA_W:0] sum, diff;
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        result = '0;
        c = 1'b0;
        case (opcode)
            OP_LDI: result = imm8;
            OP_ADD: {c, result} = sum;
            OP_SUB: {c, result} = diff;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: {c, result} = {a, 1'b0};
            OP_SHR: {result, c} = {1'b0, a};
            OP_MOV: result = a;
            default: ;
        endcase
    end
    assign z = result == '0;
    assign writes_rd = opcode >= OP_LDI && opcode <= OP_MOV;
    assign updates_flags = opcode >= OP_ADD && opcode <= OP_SHR;
    assign illegal = opcode > OP_MOV;
endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: four-state IDLE/READ/EXEC/WRITE sequencer driving a 2R1W register file
// Operands are captured in READ, so write-back to a source register cannot disturb them.
module regfile_sequencer
    import regfile_seq_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    regfile_sequencer_if.slave bus,
    input  logic [DATA_W-1:0] Out_A,
    input  logic [DATA_W-1:0] Out_B,
    output logic [ADDR_W-1:0] Addr_A,
    output logic [ADDR_W-1:0] Addr_B,
    output logic [ADDR_W-1:0] Addr_WR,
    output logic              WR,
    output logic [DATA_W-1:0] DIN
);
    state_t state, state_n;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0] op_a, op_b, din_q, alu_res;
    logic [ADDR_W-1:0] awr_q;
    logic wr_q, err_q, fc, fz;
    logic alu_c, alu_z, alu_wr, alu_upd, alu_ill;
    regfile_alu u_alu (
        .opcode(ir[OP_LSB +: 4]),
        .a(op_a),
        .b(op_b),
        .imm8(ir[DATA_W-1:0]),
        .result(alu_res),
        .c(alu_c),
        .z(alu_z),
        .writes_rd(alu_wr),
        .updates_flags(alu_upd),
        .illegal(alu_ill)
    );
    always_ff @(posedge Clock)
        state <= Reset ? IDLE : state_n;
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:  state_n = bus.instr_valid ? READ : IDLE;
            READ:  state_n = EXEC;
            EXEC:  state_n = WRITE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ir <= '0;
            op_a <= '0;
            op_b <= '0;
            awr_q <= '0;
            din_q <= '0;
            wr_q <= 1'b0;
            err_q <= 1'b0;
            fc <= 1'b0;
            fz <= 1'b0;
        end else begin
            if (state == IDLE && bus.instr_valid) ir <= bus.instr;
            if (state == READ) begin
                op_a <= Out_A;
                op_b <= Out_B;
            end
            if (state == EXEC) begin
                wr_q <= alu_wr;
                err_q <= alu_ill;
                if (alu_wr) begin
                    awr_q <= ir[RD_LSB +: ADDR_W];
                    din_q <= alu_res;
                end
                if (alu_upd) begin
                    fc <= alu_c;
                    fz <= alu_z;
                end
            end
        end
    end
    // Retirement strobes are gated by Reset so a write in flight is dropped that same cycle.
    always_comb begin
        bus.instr_ready = state == IDLE && !Reset;
        bus.busy = state != IDLE;
        bus.done = state == WRITE && !Reset;
        bus.err = state == WRITE && !Reset && err_q;
        bus.flag_c = fc;
        bus.flag_z = fz;
        WR = state == WRITE && !Reset && wr_q;
        Addr_A = ir[RA_LSB +: ADDR_W];
        Addr_B = ir[RB_LSB +: ADDR_W];
        Addr_WR = awr_q;
        DIN = din_q;
    end
endmodule
